uxrx_receiver: RTL and testbench
================================

UXRX_RECEIVER -- requirements
Module: uxrx_receiver

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the auto-baud count and of the internal bit timers.
REQ-002 SHALL have parameter DEF_BRG, default 16'd6944, the 8-bit-time reload value used after reset (868 cycles per bit).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port UxRX  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port ABAUD  input  1  auto-baud in progress; receiver held idle while high.
REQ-007 SHALL have port ldReg  input  1  one-cycle load strobe from the auto-baud controller.
REQ-008 SHALL have port brgCnt  input  CNT_W  measured cycle count spanning 8 bit times.
REQ-009 SHALL have port rxData  output  8  last received byte.
REQ-010 SHALL have port rxValid  output  1  rxData holds an unread byte.
REQ-011 SHALL have port rxRd  input  1  consumer read strobe; clears rxValid.
REQ-012 SHALL have port UxRXIF  output  1  one-cycle pulse when a byte is written to rxData.
REQ-013 SHALL have ports FERR and OERR, both output 1, sticky framing and overrun flags, cleared only by rst.

Function
REQ-014 SHALL pass UxRX through a 2-flop synchronizer; all detection SHALL use the synchronized value.
REQ-015 SHALL latch brgReg <= brgCnt when ldReg=1 and brgCnt >= 32; otherwise brgReg SHALL keep its value.
REQ-016 SHALL use bitT = brgReg>>3 cycles per bit and halfT = brgReg>>4 cycles per half-bit, with truncating division.
REQ-017 SHALL implement the states IDLE, START, DATA, STOP (plus PAR when the option is enabled).
REQ-018 SHALL leave IDLE for START on a synchronized 1->0 edge while ABAUD=0, and SHALL load the timer with halfT.
REQ-019 SHALL, at START timer expiry, enter DATA with timer=bitT if the line is 0; if the line is 1 it SHALL treat the event as a false start and return to IDLE with no flags.
REQ-020 SHALL, in DATA, sample the line at each timer expiry and shift it in LSB first; after the 8th sample it SHALL enter STOP (or PAR) with timer=bitT.
REQ-021 SHALL, in STOP at timer expiry, return to IDLE and, if the line is 1, write rxData, set rxValid and pulse UxRXIF for exactly 1 cycle.
REQ-022 SHALL, if the stop-bit sample is 0, set FERR, discard the byte and hold in IDLE until the line is sampled 1.
REQ-023 SHALL, if a byte completes while rxValid=1 and rxRd=0, set OERR, discard the new byte, leave rxData unchanged and produce no UxRXIF.
REQ-024 SHALL give precedence to the completing byte when rxRd=1 and a byte completes in the same cycle: rxValid stays 1 and the new data is stored.
REQ-025 SHALL abort any frame to IDLE within 1 cycle of ABAUD=1, with no flag and no data change.
REQ-026 SHALL apply a ldReg that arrives mid-frame from the next frame only; the current frame SHALL keep its timing.

Reset
REQ-027 SHALL, on rst=1 at posedge clk, set state=IDLE, brgReg=DEF_BRG, rxData=0, rxValid=0, UxRXIF=0, FERR=0, OERR=0, synchronizer flops=1 and PERR=0 (when present).

Configuration
REQ-028 SHALL, with UXRX_PARITY_EN defined, insert state PAR after DATA that samples an even-parity bit, and SHALL add output PERR (sticky, 1 bit) that is set when the parity of the data bits and the parity bit is odd; the byte is still stored.
REQ-029 SHALL, without UXRX_PARITY_EN, have no PAR state and no PERR port, and DATA SHALL go directly to STOP.

Structure
REQ-030 SHALL place the state encoding constants and the minimum load threshold (32) in the shared package uxrx_pkg.
REQ-031 SHALL implement the synchronizer and edge detector as the sub-module uxrx_sync.

Verification
REQ-032 SHALL verify: reset, then byte 0xA5 at 868 cycles/bit -> rxData=0xA5, UxRXIF single pulse, FERR=0, OERR=0.
REQ-033 SHALL verify: ldReg with brgCnt=800, then 0x3C at 100 cycles/bit -> rxData=0x3C; ldReg with brgCnt=20 -> brgReg unchanged.
REQ-034 SHALL verify: a 0-pulse of 200 cycles at 868 cycles/bit -> no UxRXIF and state back to IDLE.
REQ-035 SHALL verify: 0x55 with stop bit 0 -> FERR=1 and rxValid=0; then line high followed by 0x12 -> rxData=0x12.
REQ-036 SHALL verify: two bytes 0x01 then 0x02 with no rxRd -> rxData=0x01, OERR=1; and rxRd coinciding with byte completion -> new data stored with rxValid=1.
REQ-037 SHALL verify: ABAUD raised mid-byte -> IDLE within 1 cycle, no flags; and with UXRX_PARITY_EN, 0x07 sent with parity bit 0 -> PERR=1.

Source files
------------

// File: rtl/uxrx_pkg.sv
// uxrx_pkg: shared constants for the UxRX serial receiver.
//   - uxrx_state_e : receiver FSM state encoding
//   - MIN_LOAD     : smallest auto-baud count accepted into the baud register
// Build option: UXRX_PARITY_EN adds the PAR state (even-parity bit after DATA).
package uxrx_pkg;

    localparam int MIN_LOAD = 32;

`ifdef UXRX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_PAR   = 3'd4
    } uxrx_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uxrx_state_e;
`endif

endpackage

// File: rtl/uxrx_sync.sv
// uxrx_sync: 2-flop synchronizer for the serial line plus falling-edge detect.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (flops reset to idle-high)
//   rx_async in   raw serial line
//   rx_sync  out  synchronized line level
//   rx_fall  out  one-cycle strobe on a synchronized 1->0 transition
module uxrx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_async,
    output logic rx_sync,
    output logic rx_fall
);

    logic rx_meta;
    logic rx_dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_dly  <= 1'b1;
        end else begin
            rx_meta <= rx_async;
            rx_sync <= rx_meta;
            rx_dly  <= rx_sync;
        end
    end

    assign rx_fall = rx_dly & ~rx_sync;

endmodule

// File: rtl/uxrx_receiver.sv
// uxrx_receiver: 8N1 serial receiver timed from an auto-baud measured count.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   UxRX            serial line (async, idle high)
//   ABAUD           auto-baud active; receiver forced idle
//   ldReg, brgCnt   load strobe and measured 8-bit-time count
//   rxData, rxValid received byte and unread flag; rxRd clears rxValid
//   UxRXIF          one-cycle pulse when rxData is written
//   FERR, OERR      sticky framing / overrun flags
//   PERR            sticky parity flag (only with UXRX_PARITY_EN)
// Build option: UXRX_PARITY_EN inserts an even-parity bit after the data.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for a start edge (or for line high after FERR)
// START   | half-bit wait, then confirm start bit is still low
// DATA    | sampling 8 data bits, LSB first, one per bit time
// PAR     | sampling the even-parity bit (parity build only)
// STOP    | sampling the stop bit, then deliver or flag the byte
module uxrx_receiver
    import uxrx_pkg::*;
#(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] DEF_BRG = CNT_W'(16'd6944)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             UxRX,
    input  logic             ABAUD,
    input  logic             ldReg,
    input  logic [CNT_W-1:0] brgCnt,
    output logic [7:0]       rxData,
    output logic             rxValid,
    input  logic             rxRd,
    output logic             UxRXIF,
    output logic             FERR,
    output logic             OERR
`ifdef UXRX_PARITY_EN
    ,
    output logic             PERR
`endif
);

    localparam logic [CNT_W-1:0] MIN_LD = CNT_W'(MIN_LOAD);

    logic             rx_s;
    logic             rx_fall;
    logic [CNT_W-1:0] brg_reg;

    uxrx_state_e      state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic [CNT_W-1:0] frame_bit_t, frame_bit_t_n;
    logic [7:0]       shift, shift_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic             wait_high, wait_high_n;
    logic [7:0]       data_n;
    logic             valid_n, if_n, ferr_n, oerr_n;
    logic             tc;
`ifdef UXRX_PARITY_EN
    logic             perr_n;
`endif

    uxrx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .rx_async (UxRX),
        .rx_sync  (rx_s),
        .rx_fall  (rx_fall)
    );

    // The baud register may change at any time; a frame in flight keeps the
    // bit time captured when it left IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            brg_reg <= DEF_BRG;
        end else if (ldReg && (brgCnt >= MIN_LD)) begin
            brg_reg <= brgCnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            frame_bit_t <= '0;
            shift       <= '0;
            bit_cnt     <= '0;
            wait_high   <= 1'b0;
            rxData      <= '0;
            rxValid     <= 1'b0;
            UxRXIF      <= 1'b0;
            FERR        <= 1'b0;
            OERR        <= 1'b0;
`ifdef UXRX_PARITY_EN
            PERR        <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            frame_bit_t <= frame_bit_t_n;
            shift       <= shift_n;
            bit_cnt     <= bit_cnt_n;
            wait_high   <= wait_high_n;
            rxData      <= data_n;
            rxValid     <= valid_n;
            UxRXIF      <= if_n;
            FERR        <= ferr_n;
            OERR        <= oerr_n;
`ifdef UXRX_PARITY_EN
            PERR        <= perr_n;
`endif
        end
    end

    // Terminal count: a load of N expires N cycles later.
    assign tc = (timer <= CNT_W'(1));

    always_comb begin
        state_n       = state;
        timer_n       = (timer != '0) ? timer - CNT_W'(1) : timer;
        frame_bit_t_n = frame_bit_t;
        shift_n       = shift;
        bit_cnt_n     = bit_cnt;
        wait_high_n   = wait_high;
        data_n        = rxData;
        valid_n       = rxRd ? 1'b0 : rxValid;
        if_n          = 1'b0;
        ferr_n        = FERR;
        oerr_n        = OERR;
`ifdef UXRX_PARITY_EN
        perr_n        = PERR;
`endif

        if (ABAUD) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wait_high) begin
                        if (rx_s) begin
                            wait_high_n = 1'b0;
                        end
                    end else if (rx_fall) begin
                        state_n       = ST_START;
                        timer_n       = brg_reg >> 4;
                        frame_bit_t_n = brg_reg >> 3;
                        bit_cnt_n     = '0;
                    end
                end
                ST_START: begin
                    if (tc) begin
                        if (!rx_s) begin
                            state_n = ST_DATA;
                            timer_n = frame_bit_t;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (tc) begin
                        shift_n   = {rx_s, shift[7:1]};
                        bit_cnt_n = bit_cnt + 3'd1;
                        timer_n   = frame_bit_t;
                        if (bit_cnt == 3'd7) begin
`ifdef UXRX_PARITY_EN
                            state_n = ST_PAR;
`else
                            state_n = ST_STOP;
`endif
                        end
                    end
                end
`ifdef UXRX_PARITY_EN
                ST_PAR: begin
                    if (tc) begin
                        if (^{shift, rx_s}) begin
                            perr_n = 1'b1;
                        end
                        state_n = ST_STOP;
                        timer_n = frame_bit_t;
                    end
                end
`endif
                ST_STOP: begin
                    if (tc) begin
                        state_n = ST_IDLE;
                        if (rx_s) begin
                            // A read in the completing cycle frees the buffer,
                            // so the new byte wins over the clear.
                            if (rxValid && !rxRd) begin
                                oerr_n = 1'b1;
                            end else begin
                                data_n  = shift;
                                valid_n = 1'b1;
                                if_n    = 1'b1;
                            end
                        end else begin
                            ferr_n      = 1'b1;
                            wait_high_n = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uxrx_receiver.sv
module tb_uxrx_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        UxRX;
    logic        ABAUD;
    logic        ldReg;
    logic [15:0] brgCnt;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxRd;
    logic        UxRXIF;
    logic        FERR;
    logic        OERR;
`ifdef UXRX_PARITY_EN
    logic        PERR;
    logic        par_flip;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int if_total = 0;
    int t_if = 0;
    int t_start = 0;
    int if_delta;
    int lat;

    uxrx_receiver dut (
        .clk    (clk),
        .rst    (rst),
        .UxRX   (UxRX),
        .ABAUD  (ABAUD),
        .ldReg  (ldReg),
        .brgCnt (brgCnt),
        .rxData (rxData),
        .rxValid(rxValid),
        .rxRd   (rxRd),
        .UxRXIF (UxRXIF),
        .FERR   (FERR),
`ifdef UXRX_PARITY_EN
        .PERR   (PERR),
`endif
        .OERR   (OERR)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (UxRXIF === 1'b1) begin
            if_total = if_total + 1;
            t_if     = cyc;
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       stop_v;
        logic       rd_before;
        logic [7:0] e_data;
        logic       e_valid;
        logic       e_ferr;
        logic       e_oerr;
        int         e_if;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rd();
        rxRd = 1'b1;
        tick(1);
        rxRd = 1'b0;
    endtask

    task automatic load_brg(input logic [15:0] v);
        ldReg  = 1'b1;
        brgCnt = v;
        tick(1);
        ldReg  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input int bt, input logic stop_v);
        t_start = cyc;
        UxRX = 1'b0;
        tick(bt);
        for (int i = 0; i < 8; i++) begin
            UxRX = d[i];
            tick(bt);
        end
`ifdef UXRX_PARITY_EN
        UxRX = (^d) ^ par_flip;
        tick(bt);
`endif
        UxRX = stop_v;
        tick(bt);
        UxRX = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] d, input int bt, input logic stop_v);
        int n0;
        n0 = if_total;
        send_frame(d, bt, stop_v);
        tick(2 * bt);
        if_delta = if_total - n0;
    endtask

    // behavioural reference for the randomized section
    logic [7:0]  m_data;
    logic        m_valid, m_ferr, m_oerr;
    int          m_brg;

    initial begin
        int n0;
        logic [7:0]  rd;
        logic        rs;
        logic        rr;
        logic [15:0] rv;
        int          bt;
        int          e_if;

        rst = 1'b1; UxRX = 1'b1; ABAUD = 1'b0; ldReg = 1'b0; brgCnt = '0; rxRd = 1'b0;
`ifdef UXRX_PARITY_EN
        par_flip = 1'b0;
`endif
        vecs[0] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1};
        vecs[1] = '{8'h55, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 0};
        vecs[2] = '{8'h12, 1'b1, 1'b0, 8'h12, 1'b1, 1'b1, 1'b0, 1};
        vecs[3] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1};
        vecs[4] = '{8'h02, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 0};
        lat = 0;

        tick(4);
        rst = 1'b0;
        tick(4);
        check("reset rxData", rxData, 8'h00);
        check("reset rxValid", rxValid, 1'b0);
        check("reset UxRXIF", UxRXIF, 1'b0);
        check("reset FERR", FERR, 1'b0);
        check("reset OERR", OERR, 1'b0);
`ifdef UXRX_PARITY_EN
        check("reset PERR", PERR, 1'b0);
`endif

        // default 868 cycles per bit
        run_frame(8'hA5, 868, 1'b1);
        check("A5 rxData", rxData, 8'hA5);
        check("A5 rxValid", rxValid, 1'b1);
        check("A5 UxRXIF pulses", if_delta, 1);
        check("A5 FERR", FERR, 1'b0);
        check("A5 OERR", OERR, 1'b0);

        // 200-cycle glitch is rejected at the half-bit check
        n0 = if_total;
        UxRX = 1'b0;
        tick(200);
        UxRX = 1'b1;
        tick(1200);
        check("false start UxRXIF", if_total - n0, 0);
        check("false start FERR", FERR, 1'b0);
        check("false start rxData", rxData, 8'hA5);

        load_brg(16'd800);
        load_brg(16'd20);

        // ABAUD abort: stop-bit 0 frame would otherwise raise FERR/OERR
        n0 = if_total;
        fork
            send_frame(8'h5A, 100, 1'b0);
            begin tick(450); ABAUD = 1'b1; end
        join
        tick(200);
        ABAUD = 1'b0;
        tick(10);
        check("abaud A FERR", FERR, 1'b0);
        check("abaud A OERR", OERR, 1'b0);
        check("abaud A UxRXIF", if_total - n0, 0);
        check("abaud A rxValid", rxValid, 1'b1);
        pulse_rd();
        check("rxRd clears rxValid", rxValid, 1'b0);
        n0 = if_total;
        fork
            send_frame(8'hC6, 100, 1'b1);
            begin tick(600); ABAUD = 1'b1; end
        join
        tick(200);
        ABAUD = 1'b0;
        tick(10);
        check("abaud B rxData", rxData, 8'hA5);
        check("abaud B rxValid", rxValid, 1'b0);
        check("abaud B UxRXIF", if_total - n0, 0);
        check("abaud B OERR", OERR, 1'b0);

        // table-driven frames at 100 cycles per bit (brgCnt=20 was ignored)
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].rd_before) pulse_rd();
            run_frame(vecs[i].d, 100, vecs[i].stop_v);
            check($sformatf("vec%0d rxData", i), rxData, vecs[i].e_data);
            check($sformatf("vec%0d rxValid", i), rxValid, vecs[i].e_valid);
            check($sformatf("vec%0d FERR", i), FERR, vecs[i].e_ferr);
            check($sformatf("vec%0d OERR", i), OERR, vecs[i].e_oerr);
            check($sformatf("vec%0d UxRXIF", i), if_delta, vecs[i].e_if);
            if (vecs[i].e_if == 1) lat = t_if - t_start;
        end

        // rxRd in the exact cycle the byte lands: new byte must win
        if (lat < 2 || lat > 2000) begin
            check("completion latency in range", lat, 1000);
        end else begin
            n0 = if_total;
            fork
                send_frame(8'h33, 100, 1'b1);
                begin tick(lat - 1); rxRd = 1'b1; tick(1); rxRd = 1'b0; end
            join
            tick(200);
            check("coincident rd rxData", rxData, 8'h33);
            check("coincident rd rxValid", rxValid, 1'b1);
            check("coincident rd UxRXIF", if_total - n0, 1);
        end

        // ldReg mid-frame only affects the next frame
        pulse_rd();
        fork
            run_frame(8'hC3, 100, 1'b1);
            begin tick(300); load_brg(16'd400); end
        join
        check("midload frame rxData", rxData, 8'hC3);
        pulse_rd();
        run_frame(8'h96, 50, 1'b1);
        check("new baud rxData", rxData, 8'h96);
        check("new baud rxValid", rxValid, 1'b1);

        // randomized frames against the reference model
        m_data = 8'h96; m_valid = 1'b1; m_ferr = 1'b1; m_oerr = 1'b1; m_brg = 400;
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 3) == 0) rv = 16'($urandom_range(0, 31));
            else                           rv = 16'($urandom_range(256, 800));
            load_brg(rv);
            if (int'(rv) >= 32) m_brg = int'(rv);
            bt = m_brg / 8;
            rd = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 4) != 0);
            rr = 1'($urandom_range(0, 1));
            if (rr) begin
                pulse_rd();
                m_valid = 1'b0;
            end
            run_frame(rd, bt, rs);
            e_if = 0;
            if (!rs) m_ferr = 1'b1;
            else if (m_valid) m_oerr = 1'b1;
            else begin
                m_data = rd; m_valid = 1'b1; e_if = 1;
            end
            check($sformatf("rnd%0d rxData", k), rxData, m_data);
            check($sformatf("rnd%0d rxValid", k), rxValid, m_valid);
            check($sformatf("rnd%0d UxRXIF", k), if_delta, e_if);
            check($sformatf("rnd%0d FERR", k), FERR, m_ferr);
            check($sformatf("rnd%0d OERR", k), OERR, m_oerr);
        end

`ifdef UXRX_PARITY_EN
        check("PERR before bad parity", PERR, 1'b0);
        load_brg(16'd800);
        pulse_rd();
        par_flip = 1'b1;
        run_frame(8'h07, 100, 1'b1);
        par_flip = 1'b0;
        check("bad parity PERR", PERR, 1'b1);
        check("bad parity rxData", rxData, 8'h07);
        check("bad parity UxRXIF", if_delta, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
